// File: rtl/vram_port_arbiter_if.sv
// rtl/vram_port_arbiter_if.sv - bundled CPU store, VGA fetch and VRAM port signals for vram_port_arbiter
// Purpose: groups every non-clock/reset signal of the arbiter.
// Ports (slave = arbiter side):
//   cpu_we/cpu_addr/cpu_data in, cpu_stall out      CPU posted-store path
//   vga_req/vga_addr in, vga_ready/vga_rvalid/vga_rdata out  VGA fetch path
//   mem_addr/mem_we/mem_wdata out, mem_rdata in     VRAM port
//   fifo_count out                                  write-FIFO occupancy
interface vram_port_arbiter_if #(
  parameter int AW        = 19,
  parameter int DW        = 32,
  parameter int FIFO_LOG2 = 2
);
  logic                 cpu_we;
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_data;
  logic                 cpu_stall;
  logic                 vga_req;
  logic [AW-1:0]        vga_addr;
  logic                 vga_ready;
  logic                 vga_rvalid;
  logic [DW-1:0]        vga_rdata;
  logic [AW-1:0]        mem_addr;
  logic                 mem_we;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;
  logic [FIFO_LOG2:0]   fifo_count;

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, vga_req, vga_addr, mem_rdata,
    output cpu_stall, vga_ready, vga_rvalid, vga_rdata,
           mem_addr, mem_we, mem_wdata, fifo_count
  );

  modport master (
    output cpu_we, cpu_addr, cpu_data, vga_req, vga_addr, mem_rdata,
    input  cpu_stall, vga_ready, vga_rvalid, vga_rdata,
           mem_addr, mem_we, mem_wdata, fifo_count
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - single-port VRAM arbiter: posted CPU write FIFO, VGA reads have priority
// Purpose: shares one VRAM port between CPU stores (queued in a small FIFO) and
//   VGA scanout reads (granted first so the line deadline is met).
// Ports:
//   clk   in  rising-edge clock
//   clrn  in  asynchronous active-low reset
//   bus   vram_port_arbiter_if.slave (CPU store path, VGA fetch path, VRAM port, fifo_count)
// Optional feature: define VRAM_WR_STARVE_GUARD_EN to force a write after
//   VGA_RUN_MAX consecutive reads while the FIFO holds data.
module vram_port_arbiter #(
  parameter int AW          = 19,
  parameter int DW          = 32,
  parameter int FIFO_LOG2   = 2,
  parameter int VGA_RUN_MAX = 3
) (
  input logic                clk,
  input logic                clrn,
  vram_port_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2+1)'(DEPTH);

  logic [AW-1:0]        fifo_addr [DEPTH];
  logic [DW-1:0]        fifo_data [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 vga_ready;
  logic                 grant_r;
  logic                 grant_w;
  logic                 rd_issued;
  logic                 rd_valid;
  logic [AW-1:0]        mem_addr_q;
  logic [DW-1:0]        mem_wdata_q;
  logic                 mem_we_q;

  // Full comes from the registered count only, so a pop in the same cycle
  // never releases a stalled store (no bypass path).
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = bus.cpu_we & ~fifo_full;
  assign grant_r    = bus.vga_req & vga_ready;
  assign grant_w    = ~grant_r & ~fifo_empty;

`ifdef VRAM_WR_STARVE_GUARD_EN
  localparam int RW = (VGA_RUN_MAX < 1) ? 1 : $clog2(VGA_RUN_MAX + 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(VGA_RUN_MAX);

  logic [RW-1:0] run_cnt;

  // Withholding vga_ready is what forces the write: with no read grant the
  // non-empty FIFO wins the port.
  assign vga_ready = ~((run_cnt == RUN_LIMIT) & ~fifo_empty);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      run_cnt <= '0;
    end else if (fifo_empty | grant_w) begin
      run_cnt <= '0;
    end else if (grant_r) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end
`else
  // Strict VGA priority; the run limit has no effect in this build.
  logic unused_run_max;
  assign unused_run_max = ^VGA_RUN_MAX;
  assign vga_ready      = 1'b1;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (grant_w) rd_ptr <= rd_ptr + 1'b1;
      case ({push, grant_w})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cpu_addr;
      fifo_data[wr_ptr] <= bus.cpu_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_issued   <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      mem_we_q <= grant_w;
      if (grant_r) begin
        mem_addr_q <= bus.vga_addr;
      end else if (grant_w) begin
        mem_addr_q  <= fifo_addr[rd_ptr];
        mem_wdata_q <= fifo_data[rd_ptr];
      end
      // Address is on the port one cycle after the grant; the synchronous
      // VRAM returns data one cycle after that.
      rd_issued <= grant_r;
      rd_valid  <= rd_issued;
    end
  end

  assign bus.cpu_stall  = bus.cpu_we & fifo_full;
  assign bus.vga_ready  = vga_ready;
  assign bus.vga_rvalid = rd_valid;
  assign bus.vga_rdata  = bus.mem_rdata;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - self-checking bench for vram_port_arbiter
module tb_vram_port_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int FIFO_LOG2 = 2;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int RUN_MAX = 3;
`ifdef VRAM_WR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk;
  logic clrn;
  int   checks;
  int   failures;

  vram_port_arbiter_if #(.AW(AW), .DW(DW), .FIFO_LOG2(FIFO_LOG2)) bus ();

  vram_port_arbiter #(
    .AW(AW), .DW(DW), .FIFO_LOG2(FIFO_LOG2), .VGA_RUN_MAX(RUN_MAX)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == 19'h00020) return 32'h12345678;
    return {13'h1B3D, a};
  endfunction

  // Synchronous-read VRAM model: data for the address presented this cycle
  // appears the next cycle.
  always @(posedge clk) bus.mem_rdata <= rd_fn(bus.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.vga_req  = 1'b0;
    bus.vga_addr = '0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_we   = 1'($urandom);
      bus.cpu_addr = AW'($urandom);
      bus.cpu_data = $urandom;
      bus.vga_req  = 1'($urandom);
      bus.vga_addr = AW'($urandom);
      tick();
      checks++;
      if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_mem: addr=%h wdata=%h we=%b required 0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_we);
      end
      checks++;
      if (bus.vga_rvalid !== 1'b0 || bus.fifo_count !== '0) begin
        failures++;
        $display("FAIL reset_rv_cnt: rvalid=%b count=%0d required 0/0", bus.vga_rvalid, bus.fifo_count);
      end
      checks++;
      if (bus.cpu_stall !== 1'b0 || bus.vga_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_comb: stall=%b ready=%b required 0/1", bus.cpu_stall, bus.vga_ready);
      end
    end
    idle_inputs();
    clrn = 1'b1;
    tick();
    checks++;
    if (bus.fifo_count !== '0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: count=%0d we=%b required 0/0", bus.fifo_count, bus.mem_we);
    end
  endtask

  task automatic test_single_store();
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 19'h00010;
    bus.cpu_data = 32'hA5A5A5A5;
    tick();
    bus.cpu_we = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd1 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL store_t1: count=%0d we=%b required 1/0", bus.fifo_count, bus.mem_we);
    end
    tick();
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'h00010 || bus.mem_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL store_t2: we=%b addr=%h data=%h required 1/00010/a5a5a5a5", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL store_t2_count: count=%0d required 0", bus.fifo_count);
    end
    tick();
  endtask

  task automatic test_vga_read();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h00020;
    #1;
    checks++;
    if (bus.vga_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_ready: ready=%b required 1", bus.vga_ready);
    end
    tick();
    bus.vga_req = 1'b0;
    checks++;
    if (bus.mem_addr !== 19'h00020 || bus.mem_we !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_t1: addr=%h we=%b rvalid=%b required 00020/0/0", bus.mem_addr, bus.mem_we, bus.vga_rvalid);
    end
    tick();
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL read_t2: rvalid=%b rdata=%h required 1/12345678", bus.vga_rvalid, bus.vga_rdata);
    end
    tick();
    checks++;
    if (bus.vga_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL read_t3: rvalid=%b required 0", bus.vga_rvalid);
    end
  endtask

  task automatic test_full_priority();
    wr_t got[$];
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h00055;
    for (int i = 1; i <= 4; i++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(32'h100 + i);
      bus.cpu_data = 32'hD0000000 + i;
      #1;
      checks++;
      if (bus.cpu_stall !== 1'b0) begin
        failures++;
        $display("FAIL full_accept%0d: stall=%b required 0", i, bus.cpu_stall);
      end
      tick();
    end
    bus.cpu_addr = 19'h00105;
    bus.cpu_data = 32'hD0000005;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.cpu_stall !== 1'b1 || bus.fifo_count !== 3'd4 || bus.mem_we !== 1'b0) begin
        failures++;
        $display("FAIL full_hold%0d: stall=%b count=%0d we=%b required 1/4/0", i, bus.cpu_stall, bus.fifo_count, bus.mem_we);
      end
      tick();
    end
    bus.vga_req = 1'b0;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL full_nobypass: stall=%b required 1", bus.cpu_stall);
    end
    tick();
    if (bus.mem_we === 1'b1) got.push_back({bus.mem_addr, bus.mem_wdata});
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL full_release: stall=%b required 0", bus.cpu_stall);
    end
    tick();
    bus.cpu_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_we === 1'b1) got.push_back({bus.mem_addr, bus.mem_wdata});
      tick();
    end
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("FAIL full_write_count: got=%0d required 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i].a !== AW'(32'h101 + i) || got[i].d !== 32'hD0000001 + i) begin
        failures++;
        $display("FAIL full_order%0d: addr=%h data=%h required %h/%h", i, got[i].a, got[i].d, AW'(32'h101 + i), 32'hD0000001 + i);
      end
    end
  endtask

  task automatic test_guard();
    bit exp_rdy [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h00077;
    for (int k = 0; k < 12; k++) begin
      bus.cpu_we   = (k < 2);
      bus.cpu_addr = AW'(32'h200 + k);
      bus.cpu_data = 32'hC0000000 + k;
      #1;
      checks++;
      if (bus.vga_ready !== exp_rdy[k]) begin
        failures++;
        $display("FAIL guard_ready%0d: ready=%b required %b", k, bus.vga_ready, exp_rdy[k]);
      end
      tick();
      checks++;
      if (bus.mem_we !== !exp_rdy[k]) begin
        failures++;
        $display("FAIL guard_we%0d: we=%b required %b", k, bus.mem_we, !exp_rdy[k]);
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_mid_reset();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h00033;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(32'h300 + i);
      bus.cpu_data = $urandom;
      tick();
    end
    bus.cpu_we = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL midrst_fill: count=%0d required 3", bus.fifo_count);
    end
    clrn = 1'b0;
    bus.vga_req = 1'b0;
    #1;
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.vga_rvalid !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear: count=%0d rvalid=%b we=%b required 0/0/0", bus.fifo_count, bus.vga_rvalid, bus.mem_we);
    end
    tick();
    clrn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.mem_we !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet%0d: we=%b rvalid=%b required 0/0", i, bus.mem_we, bus.vga_rvalid);
      end
    end
  endtask

  // Random traffic against a queue-based reference model.
  task automatic test_random();
    wr_t           q[$];
    int            run;
    bit            r_grant;
    bit            w_grant;
    bit            exp_stall;
    bit            exp_ready;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            rv1;
    bit            rv2;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    bit            hold_cpu;
    bit            hold_vga;
    wr_t           head;

    idle_inputs();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    run = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    rv1 = 0; rv2 = 0; ra1 = '0; ra2 = '0;
    hold_cpu = 0; hold_vga = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold_cpu) begin
        bus.cpu_we   = ($urandom_range(0, 99) < 50);
        bus.cpu_addr = AW'($urandom);
        bus.cpu_data = $urandom;
      end
      if (!hold_vga) begin
        bus.vga_req  = ($urandom_range(0, 99) < 60);
        bus.vga_addr = AW'($urandom);
      end
      #1;
      exp_stall = bus.cpu_we && (q.size() == DEPTH);
      exp_ready = GUARD ? !(run == RUN_MAX && q.size() > 0) : 1'b1;
      checks++;
      if (bus.cpu_stall !== exp_stall || bus.vga_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_comb c%0d: stall=%b ready=%b required %b/%b", cyc, bus.cpu_stall, bus.vga_ready, exp_stall, exp_ready);
      end

      r_grant = bus.vga_req && exp_ready;
      w_grant = !r_grant && (q.size() > 0);
      if (GUARD) begin
        if (q.size() == 0 || w_grant) run = 0;
        else if (r_grant) run = run + 1;
      end
      exp_we = w_grant;
      if (r_grant) begin
        exp_addr = bus.vga_addr;
      end else if (w_grant) begin
        head = q.pop_front();
        exp_addr  = head.a;
        exp_wdata = head.d;
      end
      if (bus.cpu_we && !exp_stall) q.push_back({bus.cpu_addr, bus.cpu_data});
      rv2 = rv1; ra2 = ra1;
      rv1 = r_grant; ra1 = bus.vga_addr;
      hold_cpu = exp_stall;
      hold_vga = bus.vga_req && !r_grant;

      tick();
      checks++;
      if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wdata) begin
        failures++;
        $display("FAIL rand_mem c%0d: we=%b addr=%h data=%h required %b/%h/%h", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_we, exp_addr, exp_wdata);
      end
      checks++;
      if (bus.fifo_count !== (FIFO_LOG2+1)'(q.size())) begin
        failures++;
        $display("FAIL rand_count c%0d: count=%0d required %0d", cyc, bus.fifo_count, q.size());
      end
      checks++;
      if (bus.vga_rvalid !== rv2 || (rv2 && bus.vga_rdata !== rd_fn(ra2))) begin
        failures++;
        $display("FAIL rand_read c%0d: rvalid=%b rdata=%h required %b/%h", cyc, bus.vga_rvalid, bus.vga_rdata, rv2, rd_fn(ra2));
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    clrn = 1'b0;
    test_reset();
    test_single_store();
    test_vga_read();
    if (GUARD) test_guard();
    else       test_full_priority();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
